nonce_collect: RTL and testbench
================================

# nonce_collect

Downstream result stage of the hashing pipeline: watches the per-cycle compare outputs (qualifier, hit flag, byte-swapped nonce) and buffers winning nonces in a small FIFO. The host drains it through a valid/ready handshake. The block counts hashes and hits, and raises `halt` to stop the upstream nonce generator once a programmed number of hits has been collected.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `HIT_LIMIT`, 1: hits accepted per run before entering DONE; 1..255.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse; IDLE→RUN.
- `clr`  in  1  synchronous clear of FIFO, counters, flags; any state→IDLE.
- `hit_valid`  in  1  compare outputs meaningful this cycle (compare stage busy).
- `hit_found`  in  1  hash below target.
- `hit_nonce`  in  32  nonce associated with `hit_found`.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  host accepts head.
- `res_nonce`  out  32  FIFO head nonce.
- `halt`  out  1  request upstream to stop issuing work.
- `overflow`  out  1  sticky; a hit was dropped because FIFO was full.
- `hit_cnt`  out  8  hits accepted this run.
- `hash_cnt`  out  48  qualified cycles in RUN (only with macro).

## Operation
- States: IDLE, RUN, DONE (2-bit, encoded in package).
- IDLE: `hit_*` ignored; `start`→RUN.
- RUN: each cycle with `hit_valid`=1 increments `hash_cnt`. A hit is `hit_valid & hit_found`. It is pushed if FIFO not full (or a pop happens the same cycle); otherwise it is dropped, `overflow` is set and `hit_cnt` does not increment.
- RUN→DONE in the cycle after the accepted push that makes `hit_cnt` == `HIT_LIMIT`.
- DONE: `hit_*` ignored; FIFO still drains; `halt`=1; `start` has no effect.
- `clr` has priority over `start` and over a simultaneous push/pop. It empties the FIFO and zeroes `hit_cnt`, `hash_cnt` and `overflow`; state→IDLE.
- `start` in RUN is ignored; counters are not reset by `start`, only by `clr`.
- Pop: `res_valid & res_ready`. Push and pop in the same cycle are both performed, including when the FIFO is full (no drop) or has one entry.
- `hit_cnt` saturates at 255; `hash_cnt` wraps modulo 2^48.

## Timing
- Reset values: `res_valid`=0, `res_nonce`=0, `halt`=0, `overflow`=0, `hit_cnt`=0, `hash_cnt`=0; state IDLE.
- Push to `res_valid`: one cycle (registered, no fall-through).
- `res_nonce` is stable while `res_valid`=1 and `res_ready`=0.
- After a pop, the next entry appears in the following cycle; back-to-back pops sustain one per cycle.
- `halt` is registered. It rises in the cycle after the limit-reaching push, so the upstream may issue up to 2 more qualified cycles; these are ignored in DONE.
- `rst_n` low mid-run: all state is cleared immediately; FIFO contents are lost.

## Configuration
- `NONCE_COLLECT_HASHCNT_EN` defined: 48-bit `hash_cnt` counter and port are present.
- Not defined: the counter is removed and `hash_cnt` is tied to 0; all other behaviour is unchanged.

## Structure
- Shared package `miner_pkg`:
  - `NONCE_W`=32, `HASHCNT_W`=48, `HITCNT_W`=8.
  - State enum `collect_state_t` {IDLE, RUN, DONE}.
- Sub-module `nonce_fifo`: synchronous FIFO, `DEPTH`×`NONCE_W`, registered output, with push/pop/full/empty and a simultaneous push/pop on full. The FSM, counters and flags live in the top.

## Test plan
- Reset, `start`, one hit with nonce 0x12345678, `res_ready`=1 → `res_valid` one cycle later with 0x12345678; `hit_cnt`=1; `halt`=1 next cycle (`HIT_LIMIT`=1).
- `HIT_LIMIT`=8, `DEPTH`=4, `res_ready`=0, 6 hits (nonces 1..6) → FIFO holds 1..4; `overflow`=1; `hit_cnt`=4; state stays RUN.
- FIFO full, push of nonce 5 and pop in the same cycle → no overflow; drain order 2,3,4,5.
- `hit_found`=1 with `hit_valid`=0, or while in IDLE → no push, no count change.
- 100 qualified cycles in RUN with the macro defined → `hash_cnt`=100. Then `clr` with `start` in the same cycle → IDLE, all counters 0, `res_valid`=0.
- `rst_n` pulsed low while the FIFO holds 3 entries → outputs return to reset values immediately; `res_valid`=0 after release.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared definitions for the hashing-pipeline result stage.
// Widths of nonce, hash counter and hit counter, the collector state
// encoding, and a saturating increment used by the hit counter.
package miner_pkg;

  localparam int NONCE_W   = 32;
  localparam int HASHCNT_W = 48;
  localparam int HITCNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } collect_state_t;

  function automatic logic [HITCNT_W-1:0] sat_inc(input logic [HITCNT_W-1:0] v);
    return (v == '1) ? v : v + HITCNT_W'(1);
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO holding winning nonces.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             synchronous flush (wins over push/pop)
//   push, din       write request and data; ignored when full unless popping
//   pop             read request; ignored when empty
//   dout            head entry, 0 when empty
//   full, empty     occupancy flags
// The head is read from registered storage, so a pushed entry first becomes
// visible the cycle after the push (no fall-through). Push and pop in the
// same cycle are both honoured, including when full.
module nonce_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic [NONCE_W-1:0] din,
  input  logic               pop,
  output logic [NONCE_W-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [NONCE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clr;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop) & ~clr;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nonce_collect.sv
// Result stage of the hashing pipeline: collects winning nonces from the
// compare stage into a FIFO drained by the host, counts hashes and hits, and
// raises halt once HIT_LIMIT hits have been accepted.
// Optional feature macro: NONCE_COLLECT_HASHCNT_EN enables the 48-bit
// hash_cnt counter; without it hash_cnt is tied to 0.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       pulse, IDLE -> RUN
//   clr                         sync clear of FIFO, counters, flags -> IDLE
//   hit_valid/found/nonce       compare-stage outputs
//   res_valid/ready/nonce       host drain handshake (FIFO head)
//   halt                        stop request to the nonce generator
//   overflow                    sticky, a hit was dropped on a full FIFO
//   hit_cnt                     hits accepted this run (saturating)
//   hash_cnt                    qualified cycles seen in RUN (wrapping)
//
// state | meaning
// IDLE  | waiting for start, compare outputs ignored
// RUN   | counting hashes, pushing hits
// DONE  | hit limit reached, halt high, FIFO still drains
module nonce_collect
  import miner_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int HIT_LIMIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clr,
  input  logic                 hit_valid,
  input  logic                 hit_found,
  input  logic [NONCE_W-1:0]   hit_nonce,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NONCE_W-1:0]   res_nonce,
  output logic                 halt,
  output logic                 overflow,
  output logic [HITCNT_W-1:0]  hit_cnt,
  output logic [HASHCNT_W-1:0] hash_cnt
);

  collect_state_t      state;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                hit;
  logic                push;
  logic                drop;
  logic [HITCNT_W-1:0] hit_next;

  assign res_valid = ~fifo_empty;
  assign pop       = res_valid & res_ready;
  assign hit       = (state == RUN) & hit_valid & hit_found;
  assign push      = hit & (~fifo_full | pop) & ~clr;
  assign drop      = hit & fifo_full & ~pop;
  assign hit_next  = sat_inc(hit_cnt);

  nonce_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .din   (hit_nonce),
    .pop   (pop),
    .dout  (res_nonce),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      halt     <= 1'b0;
      overflow <= 1'b0;
      hit_cnt  <= '0;
    end else if (clr) begin
      state    <= IDLE;
      halt     <= 1'b0;
      overflow <= 1'b0;
      hit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (push) begin
            hit_cnt <= hit_next;
            // halt rises together with the DONE transition
            if (hit_next == HITCNT_W'(HIT_LIMIT)) begin
              state <= DONE;
              halt  <= 1'b1;
            end
          end
          if (drop) overflow <= 1'b1;
        end
        DONE: begin
          halt <= 1'b1;
        end
        default: begin
          state <= IDLE;
          halt  <= 1'b0;
        end
      endcase
    end
  end

`ifdef NONCE_COLLECT_HASHCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_cnt <= '0;
    end else if (clr) begin
      hash_cnt <= '0;
    end else if ((state == RUN) && hit_valid) begin
      hash_cnt <= hash_cnt + HASHCNT_W'(1);
    end
  end
`else
  assign hash_cnt = '0;
`endif

endmodule

// File: tb/tb_nonce_collect.sv
// Self-checking bench for nonce_collect: directed scenarios plus random
// stimulus, all compared against a queue-based reference model.
module tb_nonce_collect;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef NONCE_COLLECT_HASHCNT_EN
  localparam bit HASH_EN = 1'b1;
`else
  localparam bit HASH_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic        hit_valid;
  logic        hit_found;
  logic [31:0] hit_nonce;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_nonce;
  logic        halt;
  logic        overflow;
  logic [7:0]  hit_cnt;
  logic [47:0] hash_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  nonce_collect #(.DEPTH(DEPTH), .HIT_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .hit_valid (hit_valid),
    .hit_found (hit_found),
    .hit_nonce (hit_nonce),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_nonce (res_nonce),
    .halt      (halt),
    .overflow  (overflow),
    .hit_cnt   (hit_cnt),
    .hash_cnt  (hash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = running, 2 = finished
  bit [31:0] m_q[$];
  int        m_mode;
  int        m_hits;
  bit        m_ovf;
  longint    m_hash;

  function automatic void model_reset();
    m_q.delete();
    m_mode = 0;
    m_hits = 0;
    m_ovf  = 1'b0;
    m_hash = 0;
  endfunction

  function automatic logic [31:0] exp_nonce();
    return (m_q.size() != 0) ? m_q[0] : 32'd0;
  endfunction

  function automatic logic [47:0] exp_hash();
    logic [47:0] h;
    h = m_hash[47:0];
    return HASH_EN ? h : 48'd0;
  endfunction

  // Apply one cycle of inputs, advance the model, land 1 ns after the edge.
  task automatic step(input bit s, input bit c, input bit hv, input bit hf,
                      input logic [31:0] n, input bit rdy);
    bit do_pop;
    int sz;
    start = s; clr = c; hit_valid = hv; hit_found = hf; hit_nonce = n; res_ready = rdy;
    sz     = m_q.size();
    do_pop = (sz != 0) && rdy;
    if (c) begin
      model_reset();
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (m_mode == 1) begin
        if (hv) m_hash++;
        if (hv && hf) begin
          if (sz < DEPTH || do_pop) begin
            m_q.push_back(n);
            if (m_hits < 255) m_hits++;
            if (m_hits == LIMIT) m_mode = 2;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end else if (m_mode == 0 && s) begin
        m_mode = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; clr = 0; hit_valid = 0; hit_found = 0;
    hit_nonce = 0; res_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid got %0b exp 0", res_valid); end
    tests_run++; if (res_nonce !== 32'd0) begin tests_failed++; $display("FAIL reset_res_nonce got %h exp 0", res_nonce); end
    tests_run++; if (halt !== 1'b0) begin tests_failed++; $display("FAIL reset_halt got %0b exp 0", halt); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    tests_run++; if (hit_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_hit_cnt got %0d exp 0", hit_cnt); end
    tests_run++; if (hash_cnt !== 48'd0) begin tests_failed++; $display("FAIL reset_hash_cnt got %0d exp 0", hash_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_hit();
    step(1, 0, 0, 0, 32'd0, 1);
    step(0, 0, 1, 1, 32'h12345678, 1);
    tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %0b exp 1", res_valid); end
    tests_run++; if (res_nonce !== 32'h12345678) begin tests_failed++; $display("FAIL single_nonce got %h exp 12345678", res_nonce); end
    tests_run++; if (hit_cnt !== 8'(m_hits)) begin tests_failed++; $display("FAIL single_hit_cnt got %0d exp %0d", hit_cnt, m_hits); end
    step(0, 0, 0, 0, 32'd0, 1);
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drained got %0b exp 0", res_valid); end
  endtask

  task automatic test_overflow();
    step(0, 1, 0, 0, 32'd0, 0);
    step(1, 0, 0, 0, 32'd0, 0);
    for (int i = 1; i <= 6; i++) step(0, 0, 1, 1, 32'(i), 0);
    tests_run++; if (hit_cnt !== 8'd4) begin tests_failed++; $display("FAIL ovf_hit_cnt got %0d exp 4", hit_cnt); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
    tests_run++; if (halt !== 1'b0) begin tests_failed++; $display("FAIL ovf_halt got %0b exp 0", halt); end
    for (int k = 1; k <= 4; k++) begin
      tests_run++; if (res_nonce !== 32'(k)) begin tests_failed++; $display("FAIL ovf_drain got %0d exp %0d", res_nonce, k); end
      step(0, 0, 0, 0, 32'd0, 1);
    end
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty got %0b exp 0", res_valid); end
  endtask

  task automatic test_full_push_pop();
    step(0, 1, 0, 0, 32'd0, 0);
    step(1, 0, 0, 0, 32'd0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 1, 32'(i), 0);
    step(0, 0, 1, 1, 32'd5, 1);
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fpp_overflow got %0b exp 0", overflow); end
    tests_run++; if (hit_cnt !== 8'd5) begin tests_failed++; $display("FAIL fpp_hit_cnt got %0d exp 5", hit_cnt); end
    for (int k = 2; k <= 5; k++) begin
      tests_run++; if (res_nonce !== 32'(k)) begin tests_failed++; $display("FAIL fpp_drain got %0d exp %0d", res_nonce, k); end
      step(0, 0, 0, 0, 32'd0, 1);
    end
  endtask

  task automatic test_unqualified();
    step(0, 1, 0, 0, 32'd0, 0);
    step(0, 0, 1, 1, 32'hAA, 0);
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_hit_valid got %0b exp 0", res_valid); end
    tests_run++; if (hit_cnt !== 8'd0) begin tests_failed++; $display("FAIL idle_hit_cnt got %0d exp 0", hit_cnt); end
    step(1, 0, 0, 0, 32'd0, 0);
    step(0, 0, 0, 1, 32'hBB, 0);
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL unq_valid got %0b exp 0", res_valid); end
    tests_run++; if (hit_cnt !== 8'd0) begin tests_failed++; $display("FAIL unq_hit_cnt got %0d exp 0", hit_cnt); end
    tests_run++; if (hash_cnt !== exp_hash()) begin tests_failed++; $display("FAIL unq_hash got %0d exp %0d", hash_cnt, exp_hash()); end
  endtask

  task automatic test_limit();
    step(0, 1, 0, 0, 32'd0, 1);
    step(1, 0, 0, 0, 32'd0, 1);
    for (int i = 1; i <= LIMIT + 2; i++) begin
      step(0, 0, 1, 1, 32'(100 + i), 1);
      tests_run++; if (halt !== (m_mode == 2)) begin tests_failed++; $display("FAIL limit_halt step %0d got %0b exp %0b", i, halt, m_mode == 2); end
      tests_run++; if (hit_cnt !== 8'(m_hits)) begin tests_failed++; $display("FAIL limit_hit_cnt step %0d got %0d exp %0d", i, hit_cnt, m_hits); end
    end
    tests_run++; if (hit_cnt !== 8'(LIMIT)) begin tests_failed++; $display("FAIL limit_final got %0d exp %0d", hit_cnt, LIMIT); end
    step(1, 0, 1, 1, 32'hDEAD, 1);
    tests_run++; if (halt !== 1'b1) begin tests_failed++; $display("FAIL done_start_halt got %0b exp 1", halt); end
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL done_ignored got %0b exp 0", res_valid); end
  endtask

  task automatic test_hashcnt();
    step(0, 1, 0, 0, 32'd0, 0);
    step(1, 0, 0, 0, 32'd0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 1, (i == 10 || i == 20), 32'(i), 0);
    tests_run++; if (hash_cnt !== (HASH_EN ? 48'd100 : 48'd0)) begin tests_failed++; $display("FAIL hash_100 got %0d exp %0d", hash_cnt, HASH_EN ? 100 : 0); end
    step(1, 1, 1, 1, 32'd77, 1);
    tests_run++; if (hash_cnt !== 48'd0) begin tests_failed++; $display("FAIL clr_hash got %0d exp 0", hash_cnt); end
    tests_run++; if (hit_cnt !== 8'd0) begin tests_failed++; $display("FAIL clr_hit_cnt got %0d exp 0", hit_cnt); end
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_valid got %0b exp 0", res_valid); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL clr_overflow got %0b exp 0", overflow); end
    step(0, 0, 1, 1, 32'd7, 0);
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL clr_idle got %0b exp 0", res_valid); end
  endtask

  task automatic test_async_reset();
    step(0, 1, 0, 0, 32'd0, 0);
    step(1, 0, 0, 0, 32'd0, 0);
    for (int i = 1; i <= 3; i++) step(0, 0, 1, 1, 32'(i + 40), 0);
    tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL arst_pre got %0b exp 1", res_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_valid got %0b exp 0", res_valid); end
    tests_run++; if (res_nonce !== 32'd0) begin tests_failed++; $display("FAIL arst_nonce got %h exp 0", res_nonce); end
    tests_run++; if (hit_cnt !== 8'd0) begin tests_failed++; $display("FAIL arst_hit_cnt got %0d exp 0", hit_cnt); end
    tests_run++; if (hash_cnt !== 48'd0) begin tests_failed++; $display("FAIL arst_hash got %0d exp 0", hash_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 32'd0, 1);
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_after got %0b exp 0", res_valid); end
  endtask

  task automatic test_random();
    bit s, c, hv, hf, rdy;
    logic [31:0] n;
    step(0, 1, 0, 0, 32'd0, 0);
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 15) == 0);
      c   = ($urandom_range(0, 59) == 0);
      hv  = ($urandom_range(0, 3) != 0);
      hf  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      n   = $urandom;
      step(s, c, hv, hf, n, rdy);
      tests_run++; if (res_valid !== (m_q.size() != 0)) begin tests_failed++; $display("FAIL rnd_valid cyc %0d got %0b exp %0b", i, res_valid, m_q.size() != 0); end
      tests_run++; if (res_nonce !== exp_nonce()) begin tests_failed++; $display("FAIL rnd_nonce cyc %0d got %h exp %h", i, res_nonce, exp_nonce()); end
      tests_run++; if (halt !== (m_mode == 2)) begin tests_failed++; $display("FAIL rnd_halt cyc %0d got %0b exp %0b", i, halt, m_mode == 2); end
      tests_run++; if (overflow !== m_ovf) begin tests_failed++; $display("FAIL rnd_overflow cyc %0d got %0b exp %0b", i, overflow, m_ovf); end
      tests_run++; if (hit_cnt !== 8'(m_hits)) begin tests_failed++; $display("FAIL rnd_hit_cnt cyc %0d got %0d exp %0d", i, hit_cnt, m_hits); end
      tests_run++; if (hash_cnt !== exp_hash()) begin tests_failed++; $display("FAIL rnd_hash cyc %0d got %0d exp %0d", i, hash_cnt, exp_hash()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_overflow();
    test_full_push_pop();
    test_unqualified();
    test_limit();
    test_hashcnt();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
